// File: rtl/dct_col_stream.sv
// Streaming 8-point forward DCT on one column per cycle, three register stages
// (butterfly, multiply, accumulate/round) under a single valid/ready enable.
module dct_col_stream #(
  parameter int SIZE        = 8,
  parameter int APPROX_BITS = 0,
  parameter int SIZE_MULT   = SIZE + 6,
  parameter int SIZE_OUT    = SIZE + 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0][SIZE-1:0]  data_in,
  input  logic                  approx_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0][SIZE+2:0]  data_out,
  output logic [2:0]            col_idx,
  output logic                  out_last
);

  localparam int YW = SIZE + 3;
  localparam logic [SIZE-1:0] KEEP_MASK = {SIZE{1'b1}} << APPROX_BITS;
  localparam logic signed [SIZE_OUT-1:0] Y_MAX = (SIZE_OUT'(1) <<< (SIZE + 2)) - SIZE_OUT'(1);
  localparam logic signed [SIZE_OUT-1:0] Y_MIN = ~Y_MAX;

  // Odd (2n+1)*k never lands on 0 or 16 for k in 1..7, so every coefficient fits 6 signed bits.
  function automatic int coef(input int k, input int n);
    int m;
    int mag;
    int neg;
    if (k == 0) return 23;
    m   = ((2 * n + 1) * k) % 32;
    neg = 0;
    if (m > 16) m = 32 - m;
    if (m > 8) begin
      m   = 16 - m;
      neg = 1;
    end
    case (m)
      0:       mag = 32;
      1:       mag = 31;
      2:       mag = 30;
      3:       mag = 27;
      4:       mag = 23;
      5:       mag = 18;
      6:       mag = 12;
      7:       mag = 6;
      default: mag = 0;
    endcase
    return (neg != 0) ? -mag : mag;
  endfunction

  logic                        w_en;
  logic                        r_v1, r_v2, r_v3;
  logic signed [SIZE-1:0]      w_x [8];
  logic signed [SIZE:0]        w_s [4];
  logic signed [SIZE:0]        w_d [4];
  logic signed [SIZE:0]        r_s [4];
  logic signed [SIZE:0]        r_d [4];
  logic signed [SIZE_MULT-1:0] w_p [8][4];
  logic signed [SIZE_MULT-1:0] r_p [8][4];
  logic signed [YW-1:0]        w_y [8];
  logic [7:0][YW-1:0]          r_y;
  logic [2:0]                  r_col;

  assign w_en      = !r_v3 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v3;
  assign data_out  = r_y;
  assign col_idx   = r_col;
  assign out_last  = r_v3 && (r_col == 3'd7);

  genvar gi, gj;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_in
      assign w_x[gi] = approx_en ? $signed(data_in[gi] & KEEP_MASK) : $signed(data_in[gi]);
    end

    for (gi = 0; gi < 4; gi++) begin : g_bfly
      assign w_s[gi] = (SIZE+1)'(w_x[gi]) + (SIZE+1)'(w_x[7-gi]);
      assign w_d[gi] = (SIZE+1)'(w_x[gi]) - (SIZE+1)'(w_x[7-gi]);
    end

    // Even rows are symmetric about the centre and use sums; odd rows are antisymmetric and use differences.
    for (gi = 0; gi < 8; gi++) begin : g_row
      for (gj = 0; gj < 4; gj++) begin : g_tap
        localparam logic signed [5:0] C = 6'(coef(gi, gj));
        if (gi % 2 == 0) begin : g_even
          assign w_p[gi][gj] = SIZE_MULT'(r_s[gj]) * SIZE_MULT'(C);
        end else begin : g_odd
          assign w_p[gi][gj] = SIZE_MULT'(r_d[gj]) * SIZE_MULT'(C);
        end
      end
    end

    for (gi = 0; gi < 8; gi++) begin : g_out
      logic signed [SIZE_OUT-1:0] w_sum;
      logic signed [SIZE_OUT-1:0] w_rnd;
      assign w_sum = SIZE_OUT'(r_p[gi][0]) + SIZE_OUT'(r_p[gi][1])
                   + SIZE_OUT'(r_p[gi][2]) + SIZE_OUT'(r_p[gi][3]);
      assign w_rnd = (w_sum + SIZE_OUT'(32)) >>> 6;
      assign w_y[gi] = (w_rnd > Y_MAX) ? Y_MAX[YW-1:0] :
                       (w_rnd < Y_MIN) ? Y_MIN[YW-1:0] : w_rnd[YW-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s <= w_s;
      r_d <= w_d;
      r_p <= w_p;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_y   <= '0;
      r_col <= 3'd0;
    end else begin
      if (w_en) begin
        r_v1 <= in_valid;
        r_v2 <= r_v1;
        r_v3 <= r_v2;
        for (int k = 0; k < 8; k++) r_y[k] <= w_y[k];
      end
      if (r_v3 && out_ready) r_col <= r_col + 3'd1;
    end
  end

endmodule

// File: doc/dct_col_stream.md
Name: dct_col_stream

Overview:
Streaming, parametrised 8-point 1-D forward DCT column engine with valid/ready flow control. It is the successor to the combinational-style column DCT. It adds a 3-stage pipeline, backpressure, per-column approximation mode, and 8-column block tracking with column index and last flag. It sits between the pixel-level-shift stage and the transpose buffer of the 2-D DCT path.

Parameters:
SIZE, 8, signed input sample width
APPROX_BITS, 0, input LSBs zeroed when approx mode is active (0..SIZE-1)
SIZE_MULT, SIZE+6, product width (sample times 6-bit signed coefficient)
SIZE_OUT, SIZE+10, internal accumulator width before rounding

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
in_valid  in  1  input column valid
in_ready  out  1  engine can accept a column this cycle
data_in  in  8 x SIZE signed  column samples x[0..7]
approx_en  in  1  approximation mode, sampled with the column
out_valid  out  1  output column valid
out_ready  in  1  downstream accepts output
data_out  out  8 x (SIZE+3) signed  DCT coefficients y[0..7]
col_idx  out  3  index of the output column within its 8-column block
out_last  out  1  high with the 8th column of a block (col_idx==7)

Behaviour:
- Reset (rst==0 at a clk edge) clears all stage valid bits, out_valid, data_out, col_idx and out_last to 0, and the block counter to 0. Reset mid-stream discards in-flight columns; no output results from them.
- Pipeline enable: en = !out_valid || out_ready; in_ready = en (combinational). A column is accepted when in_valid && in_ready.
- While en==0, every stage holds: data_out, col_idx and out_last stay stable and out_valid stays 1.
- Latency is 3 cycles from acceptance to out_valid when there is no stall. Throughput is 1 column/cycle.
- Stage 1: if the sampled approx_en==1, x'[n] = x[n] with its low APPROX_BITS forced to 0; otherwise x'[n] = x[n]. Then form butterflies s[n]=x'[n]+x'[7-n] and d[n]=x'[n]-x'[7-n] for n=0..3, each SIZE+1 bits.
- Stage 2: multiply the butterflies by the coefficients; products are SIZE_MULT bits and are registered.
- Stage 3: accumulate into SIZE_OUT bits and round: y[k] = (sum + 32) >>> 6, using an arithmetic shift. Saturate to the SIZE+3 signed range.
- Coefficients: M[0][n]=23 for all n. For k>=1, M[k][n]=Q(((2n+1)k) mod 32), with Q(0)=32 and Q(1..7)=31,30,27,23,18,12,6. Q(8)=0, Q(16-m)=-Q(m) for 0<m<16, and Q(32-m)=Q(m). The result must be bit-exact to sum over n of x'[n]*M[k][n].
- Block counter: increments on every output handshake (out_valid && out_ready) and wraps 7 -> 0. col_idx shows the counter value. out_last = out_valid && col_idx==7.
- approx_en travels with its own column; toggling it between columns affects only the columns accepted after the change.
- Acceptance and output handshake in the same cycle are legal; the pipeline advances normally.

Test Plan:
- All x=100, approx_en=0 -> y[0]=288 and y[1..7]=0, out_valid exactly 3 cycles after acceptance.
- Impulse x[0]=64, others 0 -> y = {23,31,30,27,23,18,12,6}.
- Extremes: all x=127 -> y[0]=365; all x=-128 -> y[0]=-368; y[1..7]=0 in both cases.
- APPROX_BITS=2, all x=3: approx_en=1 -> all y=0; the next column with approx_en=0 -> y[0]=9.
- Backpressure: stream 4 columns with out_ready=0. After 3 accepts in_ready drops and the outputs stay stable. Raising out_ready drains the columns in order with no loss or duplication.
- Stream 10 columns with out_ready=1 -> col_idx 0..7,0,1, and out_last high only on the 8th output. Asserting rst=0 mid-stream clears out_valid next cycle and the following block restarts at col_idx=0.
